// File: rtl/axi_slave_mem.sv
// AXI slave memory responder: independent write (AW/W/B) and read (AR/R) engines
// sharing one word-addressed RAM; FIXED/INCR/WRAP bursts of 32-bit beats.
module axi_slave_mem #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        aclk,
    input  logic        arst,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    logic [31:0] mem [DEPTH];

    function automatic logic out_of_range(input logic [31:0] addr);
        return (addr < BASE_ADDR) || (((addr - BASE_ADDR) >> 2) >= DEPTH_W);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        return AW'((addr - BASE_ADDR) >> 2);
    endfunction

    function automatic logic burst_bad(input logic [1:0] burst, input logic [3:0] len);
        return (burst == 2'b11) ||
               (burst == 2'b10 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    endfunction

    // Wrap mask is (len+1)*4-1, i.e. len with two low ones appended.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [1:0] burst);
        if (burst == 2'b00)
            return addr;
        if (burst == 2'b10 && !burst_bad(burst, len))
            return (addr & ~{26'd0, len, 2'b11}) | ((addr + 32'd4) & {26'd0, len, 2'b11});
        return addr + 32'd4;
    endfunction

    wstate_t     w_state, w_state_n;
    logic [3:0]  w_id, w_id_n, w_len, w_len_n, w_cnt, w_cnt_n;
    logic [1:0]  w_burst, w_burst_n;
    logic [31:0] w_addr, w_addr_n;
    logic        w_err, w_err_n, w_wr, w_beat_err;
    logic        awready_n, wready_n, bvalid_n;
    logic [3:0]  bid_n;
    logic [1:0]  bresp_n;

    rstate_t     r_state, r_state_n;
    logic [3:0]  r_len, r_len_n, r_cnt, r_cnt_n;
    logic [1:0]  r_burst, r_burst_n;
    logic [31:0] r_addr, r_addr_n;
    logic        r_err, r_err_n;
    logic        arready_n, rvalid_n, rlast_n;
    logic [3:0]  rid_n;
    logic [31:0] rdata_n;
    logic [1:0]  rresp_n;
    logic [31:0] ld_addr, ld_data;
    logic        ld_oor;

    assign w_beat_err = out_of_range(w_addr) || (wlast != (w_cnt == w_len));

    always_comb begin
        w_state_n = w_state;
        awready_n = awready;
        wready_n  = wready;
        bvalid_n  = bvalid;
        bid_n     = bid;
        bresp_n   = bresp;
        w_id_n    = w_id;
        w_addr_n  = w_addr;
        w_len_n   = w_len;
        w_burst_n = w_burst;
        w_cnt_n   = w_cnt;
        w_err_n   = w_err;
        w_wr      = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready_n = 1'b1;
                if (awvalid && awready) begin
                    w_id_n    = awid;
                    w_addr_n  = awaddr;
                    w_len_n   = awlen;
                    w_burst_n = awburst;
                    w_cnt_n   = 4'd0;
                    w_err_n   = burst_bad(awburst, awlen);
                    awready_n = 1'b0;
                    wready_n  = 1'b1;
                    w_state_n = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready) begin
                    w_wr     = !out_of_range(w_addr);
                    w_addr_n = next_addr(w_addr, w_len, w_burst);
                    w_cnt_n  = w_cnt + 4'd1;
                    w_err_n  = w_err || w_beat_err;
                    if (w_cnt == w_len) begin
                        wready_n  = 1'b0;
                        bvalid_n  = 1'b1;
                        bid_n     = w_id;
                        bresp_n   = (w_err || w_beat_err) ? 2'b10 : 2'b00;
                        w_state_n = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid && bready) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    // Beat load source: AR address on acceptance, otherwise the running burst address.
    assign ld_addr = (r_state == R_IDLE) ? araddr : r_addr;
    assign ld_oor  = out_of_range(ld_addr);
    assign ld_data = ld_oor ? 32'h0 : mem[word_idx(ld_addr)];

    always_comb begin
        r_state_n = r_state;
        arready_n = arready;
        rvalid_n  = rvalid;
        rlast_n   = rlast;
        rid_n     = rid;
        rdata_n   = rdata;
        rresp_n   = rresp;
        r_addr_n  = r_addr;
        r_len_n   = r_len;
        r_burst_n = r_burst;
        r_cnt_n   = r_cnt;
        r_err_n   = r_err;
        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (arvalid && arready) begin
                    rid_n     = arid;
                    r_len_n   = arlen;
                    r_burst_n = arburst;
                    r_err_n   = burst_bad(arburst, arlen);
                    r_addr_n  = next_addr(araddr, arlen, arburst);
                    r_cnt_n   = 4'd0;
                    rdata_n   = ld_data;
                    rresp_n   = (burst_bad(arburst, arlen) || ld_oor) ? 2'b10 : 2'b00;
                    rlast_n   = (arlen == 4'd0);
                    rvalid_n  = 1'b1;
                    arready_n = 1'b0;
                    r_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid && rready) begin
                    if (rlast) begin
                        rvalid_n  = 1'b0;
                        rlast_n   = 1'b0;
                        arready_n = 1'b1;
                        r_state_n = R_IDLE;
                    end else begin
                        rdata_n  = ld_data;
                        rresp_n  = (r_err || ld_oor) ? 2'b10 : 2'b00;
                        rlast_n  = ((r_cnt + 4'd1) == r_len);
                        r_cnt_n  = r_cnt + 4'd1;
                        r_addr_n = next_addr(r_addr, r_len, r_burst);
                    end
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= 4'd0;
            bresp   <= 2'b00;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= 4'd0;
            rdata   <= 32'h0;
            rresp   <= 2'b00;
            w_cnt   <= 4'd0;
            w_err   <= 1'b0;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            w_state <= w_state_n;
            r_state <= r_state_n;
            awready <= awready_n;
            wready  <= wready_n;
            bvalid  <= bvalid_n;
            bid     <= bid_n;
            bresp   <= bresp_n;
            arready <= arready_n;
            rvalid  <= rvalid_n;
            rlast   <= rlast_n;
            rid     <= rid_n;
            rdata   <= rdata_n;
            rresp   <= rresp_n;
            w_cnt   <= w_cnt_n;
            w_err   <= w_err_n;
            r_cnt   <= r_cnt_n;
            r_err   <= r_err_n;
        end
    end

    always_ff @(posedge aclk) begin
        w_id    <= w_id_n;
        w_addr  <= w_addr_n;
        w_len   <= w_len_n;
        w_burst <= w_burst_n;
        r_addr  <= r_addr_n;
        r_len   <= r_len_n;
        r_burst <= r_burst_n;
    end

    // RAM contents survive reset; a beat on the reset edge is dropped.
    always_ff @(posedge aclk) begin
        if (arst && w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i])
                    mem[word_idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end
endmodule
